count_job_arbiter: RTL and testbench
====================================

COUNT_JOB_ARBITER -- requirements
Module: count_job_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the shared counter and of each job load value.
REQ-002 Parameter NREQ, default 4: number of requesters, 2..16; IDW = max(1, $clog2(NREQ)).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NREQ  per-requester job request.
REQ-006 req_ready  output  NREQ  one-hot accept strobe; at most one bit high in any cycle.
REQ-007 req_value  input  NREQ*WIDTH  flattened start values; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 req_dir  input  NREQ  per-requester direction: 1 = up to all-ones, 0 = down to zero.
REQ-009 tick_en  input  1  count-step enable for the running job.
REQ-010 abort  input  1  terminates the running job.
REQ-011 cpl_valid  output  1  one-cycle job completion pulse.
REQ-012 cpl_id  output  IDW  index of the completing requester; valid while cpl_valid is high.
REQ-013 cpl_aborted  output  1  completion was caused by abort; valid while cpl_valid is high.
REQ-014 count  output  WIDTH  current shared counter value.
REQ-015 busy  output  1  high in RUN and DONE.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 IDLE: if any req_valid bit is high, the block SHALL select one requester, assert its req_ready combinationally in that cycle, and on the clock edge load count with that requester's req_value, capture req_dir and the requester index, and enter RUN.
REQ-018 Arbitration SHALL be round-robin: search starts at (last granted index + 1) mod NREQ.
REQ-019 RUN, terminal check: if count equals the terminal value (0 when down, all-ones when up), the FSM SHALL enter DONE without stepping.
REQ-020 RUN, stepping: otherwise, if tick_en is high, count SHALL move by exactly 1 toward the terminal; if tick_en is low, count SHALL hold.
REQ-021 The counter SHALL never wrap; the step is blocked at the terminal value.
REQ-022 RUN, abort: if abort is high and count is not at the terminal value, the FSM SHALL enter DONE with the aborted flag set and count held.
REQ-023 Abort and terminal in the same cycle: the terminal SHALL win and cpl_aborted SHALL be 0.
REQ-024 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-025 In DONE, cpl_valid = 1, cpl_id = captured index and cpl_aborted = the aborted flag.
REQ-026 In DONE and RUN, req_ready SHALL be 0; a new job is accepted no earlier than the IDLE cycle following DONE.
REQ-027 Latency: with tick_en held high, a job accepted in cycle 0 SHALL produce cpl_valid in cycle N+2, where N is the step distance to the terminal (N = V down, N = all-ones − V up).
REQ-028 count SHALL hold its last value through DONE and IDLE until the next load.
REQ-029 abort SHALL be ignored in IDLE and DONE.

Reset
REQ-030 On rst_n low, regardless of clk, the block SHALL enter IDLE and drive count = 0, busy = 0, cpl_valid = 0, cpl_id = 0, cpl_aborted = 0 and req_ready = 0.
REQ-031 On reset, the round-robin pointer SHALL make requester 0 highest priority.
REQ-032 A reset during RUN SHALL discard the job with no completion pulse.

Configuration
REQ-033 With macro COUNT_JOB_ARBITER_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (lowest index wins) and the round-robin pointer SHALL be omitted.
REQ-034 Without COUNT_JOB_ARBITER_FIXED_PRIO_EN, REQ-018 round-robin applies.

Verification
REQ-035 Req0, value 5, dir 0, tick_en=1 accepted in cycle 0 -> count 5,4,3,2,1,0; cpl_valid in cycle 7, cpl_id=0, cpl_aborted=0.
REQ-036 Req2, value 8'hFD, dir 1 -> count FE then FF, no wrap; cpl_valid 4 cycles after accept; count holds FF afterwards.
REQ-037 All 4 req_valid held high, round-robin build -> grant order 0,1,2,3,0; with COUNT_JOB_ARBITER_FIXED_PRIO_EN -> grant order 0,0,0.
REQ-038 Req1, value 10, dir 0, abort pulsed at count=6 -> cpl_valid next cycle with cpl_aborted=1, count holds 6; abort in the same cycle as count=0 -> cpl_aborted=0.
REQ-039 Value 0, dir 0 -> cpl_valid in cycle 2; with tick_en toggling 1/0, count decrements only in tick_en cycles.
REQ-040 rst_n asserted mid-RUN (count=3) -> outputs reset immediately, no cpl_valid; first grant after release goes to requester 0.

Source files
------------

// File: rtl/count_job_arbiter_if.sv
// count_job_arbiter_if: request/completion bus between job requesters and the count_job_arbiter
// master (requester side) drives req_valid, req_value, req_dir, tick_en, abort and observes
// req_ready, cpl_valid, cpl_id, cpl_aborted, count, busy; slave (arbiter side) is the mirror.
interface count_job_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_dir;
  logic [NREQ*WIDTH-1:0] req_value;
  logic                  tick_en;
  logic                  abort;
  logic                  cpl_valid;
  logic [IDW-1:0]        cpl_id;
  logic                  cpl_aborted;
  logic [WIDTH-1:0]      count;
  logic                  busy;
  modport master (
    output req_valid, req_value, req_dir, tick_en, abort,
    input  req_ready, cpl_valid, cpl_id, cpl_aborted, count, busy
  );
  modport slave (
    input  req_valid, req_value, req_dir, tick_en, abort,
    output req_ready, cpl_valid, cpl_id, cpl_aborted, count, busy
  );
endinterface

// File: rtl/count_job_arbiter.sv
// count_job_arbiter: arbitrates counting jobs from NREQ requesters onto one shared up/down counter
// Ports: clk, rst_n (async active-low), bus (count_job_arbiter_if.slave: requests in, grant/completion/count out).
// Build option: COUNT_JOB_ARBITER_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module count_job_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  count_job_arbiter_if.slave    bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             aborted_q, aborted_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   base, scan, gnt_id;
  logic             gnt_any, term, load;
`ifdef COUNT_JOB_ARBITER_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [IDW-1:0] ptr_q, ptr_d;
  assign base  = ptr_q;
  assign ptr_d = load ? IDW'((int'(gnt_id) + 1) % NREQ) : ptr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
`endif
  // First valid requester found scanning upward from base, wrapping at NREQ
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    scan    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = IDW'((int'(base) + k) % NREQ);
      if (!gnt_any && bus.req_valid[scan]) begin
        gnt_any = 1'b1;
        gnt_id  = scan;
      end
    end
  end
  assign load = (state_q == IDLE) && gnt_any;
  assign term = dir_q ? &count_q : ~|count_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      dir_q     <= 1'b0;
      aborted_q <= 1'b0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      dir_q     <= dir_d;
      aborted_q <= aborted_d;
      id_q      <= id_d;
    end
  // Terminal check precedes abort, so a job reaching its end never reports aborted
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    dir_d     = dir_q;
    aborted_d = aborted_q;
    id_d      = id_q;
    if (load) begin
      state_d   = RUN;
      count_d   = bus.req_value[int'(gnt_id)*WIDTH +: WIDTH];
      dir_d     = bus.req_dir[gnt_id];
      id_d      = gnt_id;
      aborted_d = 1'b0;
    end else if (state_q == RUN) begin
      if (term) begin
        state_d   = DONE;
        aborted_d = 1'b0;
      end else if (bus.abort) begin
        state_d   = DONE;
        aborted_d = 1'b1;
      end else if (bus.tick_en) begin
        count_d = dir_q ? count_q + 1'b1 : count_q - 1'b1;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // Grant strobe is held off while reset is asserted even though it is combinational
  always_comb begin
    bus.req_ready = '0;
    if (load && rst_n) bus.req_ready[gnt_id] = 1'b1;
    bus.cpl_valid   = state_q == DONE;
    bus.cpl_id      = (state_q == DONE) ? id_q : '0;
    bus.cpl_aborted = (state_q == DONE) && aborted_q;
    bus.count       = count_q;
    bus.busy        = state_q != IDLE;
  end
endmodule

// File: tb/tb_count_job_arbiter.sv
// tb_count_job_arbiter: directed vector table plus hand sequences for count_job_arbiter
module tb_count_job_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int total = 0;
  int bad = 0;
  typedef struct {
    int v, val, d, t, a;
    int r, c, cv, id, cab, b;
  } vec_t;
  vec_t tab[$];
  int exp_g[5];
  count_job_arbiter_if #(.WIDTH(8), .NREQ(4)) bus ();
  count_job_arbiter #(.WIDTH(8), .NREQ(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic drive(input int v, input int val, input int d, input int t, input int a);
    bus.req_valid = 4'(v);
    bus.req_value = {4{8'(val)}};
    bus.req_dir   = {4{1'(d)}};
    bus.tick_en   = 1'(t);
    bus.abort     = 1'(a);
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, ".count"}, bus.count, 0);
    chk({nm, ".busy"}, bus.busy, 0);
    chk({nm, ".cv"}, bus.cpl_valid, 0);
    chk({nm, ".cid"}, bus.cpl_id, 0);
    chk({nm, ".cab"}, bus.cpl_aborted, 0);
    chk({nm, ".rdy"}, bus.req_ready, 0);
  endtask
  initial begin
    // v, val, dir, tick, abort | ready, count, cpl_valid, cpl_id, cpl_aborted, busy
    tab.push_back(vec_t'{1, 5, 0, 1, 0,  1, 0, 0, 0, 0, 0});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 5, 0, 0, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 4, 0, 0, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 3, 0, 0, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 2, 0, 0, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 0, 1, 0, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0});
    tab.push_back(vec_t'{4, 'hFD, 1, 1, 0,  4, 0, 0, 0, 0, 0});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 'hFD, 0, 0, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 'hFE, 0, 0, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 'hFF, 0, 0, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 'hFF, 1, 2, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 'hFF, 0, 0, 0, 0});
    tab.push_back(vec_t'{2, 10, 0, 1, 0,  2, 'hFF, 0, 0, 0, 0});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 10, 0, 0, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 9, 0, 0, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 8, 0, 0, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 7, 0, 0, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 1, 1,  0, 6, 0, 0, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 6, 1, 1, 1, 1});
    tab.push_back(vec_t'{0, 0, 0, 1, 1,  0, 6, 0, 0, 0, 0});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 6, 0, 0, 0, 0});
    tab.push_back(vec_t'{8, 1, 0, 1, 0,  8, 6, 0, 0, 0, 0});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 1, 1,  0, 0, 1, 3, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0});
    tab.push_back(vec_t'{3, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0});
    tab.push_back(vec_t'{3, 0, 0, 1, 0,  0, 0, 0, 0, 0, 1});
    tab.push_back(vec_t'{3, 0, 0, 1, 0,  0, 0, 1, 0, 0, 1});
    tab.push_back(vec_t'{6, 3, 0, 1, 0,  2, 0, 0, 0, 0, 0});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 3, 0, 0, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 0, 0,  0, 2, 0, 0, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 2, 0, 0, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 0, 1, 1, 0, 1});
    tab.push_back(vec_t'{0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0});
`ifdef COUNT_JOB_ARBITER_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0, 0};
`else
    exp_g = '{0, 1, 2, 3, 0};
`endif
    drive('hF, 'hAA, 1, 1, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset("rst");
    @(negedge clk);
    @(negedge clk);
    #1 chk_reset("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < tab.size(); i++) begin
      @(negedge clk);
      drive(tab[i].v, tab[i].val, tab[i].d, tab[i].t, tab[i].a);
      #1;
      chk($sformatf("v%0d.rdy", i), bus.req_ready, tab[i].r);
      chk($sformatf("v%0d.count", i), bus.count, tab[i].c);
      chk($sformatf("v%0d.cv", i), bus.cpl_valid, tab[i].cv);
      chk($sformatf("v%0d.busy", i), bus.busy, tab[i].b);
      if (tab[i].cv != 0) begin
        chk($sformatf("v%0d.cid", i), bus.cpl_id, tab[i].id);
        chk($sformatf("v%0d.cab", i), bus.cpl_aborted, tab[i].cab);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      drive('hF, 0, 0, 1, 0);
      #1 chk($sformatf("rr%0d.rdy", g), bus.req_ready, 1 << exp_g[g]);
      @(negedge clk);
      #1;
      chk($sformatf("rr%0d.run_rdy", g), bus.req_ready, 0);
      chk($sformatf("rr%0d.busy", g), bus.busy, 1);
      @(negedge clk);
      #1;
      chk($sformatf("rr%0d.cv", g), bus.cpl_valid, 1);
      chk($sformatf("rr%0d.cid", g), bus.cpl_id, exp_g[g]);
      chk($sformatf("rr%0d.done_rdy", g), bus.req_ready, 0);
    end
    @(negedge clk);
    drive(4, 5, 0, 1, 0);
    #1 chk("mr.rdy", bus.req_ready, 4);
    @(negedge clk);
    drive(0, 0, 0, 1, 0);
    #1 chk("mr.c5", bus.count, 5);
    @(negedge clk);
    #1 chk("mr.c4", bus.count, 4);
    @(negedge clk);
    #1 chk("mr.c3", bus.count, 3);
    #2;
    drive('hF, 0, 0, 1, 0);
    rst_n = 1'b0;
    #1 chk_reset("mr.rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("mr.hold%0d.cv", i), bus.cpl_valid, 0);
      chk($sformatf("mr.hold%0d.busy", i), bus.busy, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mr.first_rdy", bus.req_ready, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1 chk("mr.first_busy", bus.busy, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
